// File: rtl/score_display.sv
// score_display: converts the selected score (run score or high score) to six
// active-low seven-segment digits using a sequential double-dabble converter.
// The displayed digits only change once a conversion has fully completed, so
// the display never shows intermediate BCD values.
module score_display #(
  parameter int unsigned MAX_VALUE = 999999
) (
  input  logic        Clock,
  input  logic        reset,
  input  logic [31:0] score,
  input  logic [31:0] highScore,
  input  logic        showHS,
  input  logic        blank,
  output logic [6:0]  HEX0,
  output logic [6:0]  HEX1,
  output logic [6:0]  HEX2,
  output logic [6:0]  HEX3,
  output logic [6:0]  HEX4,
  output logic [6:0]  HEX5,
  output logic        busy,
  output logic        overflow
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    LOAD  = 2'd1,
    SHIFT = 2'd2,
    DONE  = 2'd3
  } state_t;

  localparam int          BIN_W      = 20;
  localparam int          BCD_W      = 24;
  localparam logic [4:0]  LAST_SHIFT = 5'(BIN_W - 1);
  localparam logic [31:0] MAX_V32    = 32'(MAX_VALUE);
  localparam logic [19:0] MAX_V20    = 20'(MAX_VALUE);
  localparam logic [6:0]  SEG_OFF    = 7'b1111111;
  localparam logic [6:0]  SEG_ZERO   = 7'b1000000;

  // Active-low {g,f,e,d,c,b,a} pattern for one decimal digit.
  function automatic logic [6:0] seg_encode(input logic [3:0] digit);
    logic [6:0] seg;
    case (digit)
      4'd0:    seg = 7'b1000000;
      4'd1:    seg = 7'b1111001;
      4'd2:    seg = 7'b0100100;
      4'd3:    seg = 7'b0110000;
      4'd4:    seg = 7'b0011001;
      4'd5:    seg = 7'b0010010;
      4'd6:    seg = 7'b0000010;
      4'd7:    seg = 7'b1111000;
      4'd8:    seg = 7'b0000000;
      4'd9:    seg = 7'b0010000;
      default: seg = SEG_OFF;
    endcase
    return seg;
  endfunction

  // Double-dabble correction: any nibble of 5 or more gets +3 before the shift,
  // so that it carries correctly into the next decade after doubling.
  function automatic logic [BCD_W-1:0] dabble_adjust(input logic [BCD_W-1:0] bcd);
    logic [BCD_W-1:0] adj;
    adj = bcd;
    for (int i = 0; i < BCD_W / 4; i++) begin
      if (bcd[i*4 +: 4] >= 4'd5) begin
        adj[i*4 +: 4] = bcd[i*4 +: 4] + 4'd3;
      end
    end
    return adj;
  endfunction

  state_t                 state_q, state_d;
  logic [31:0]            last_value_q, last_value_d;
  logic                   last_sel_q, last_sel_d;
  logic [BIN_W-1:0]       bin_q, bin_d;
  logic [BCD_W-1:0]       bcd_q, bcd_d;
  logic [4:0]             cnt_q, cnt_d;
  logic                   pend_ovf_q, pend_ovf_d;
  logic [5:0][6:0]        seg_q, seg_d;
  logic                   ovf_q, ovf_d;
  logic                   blank_q;

  logic [31:0]            sel_value;
  logic [BCD_W-1:0]       bcd_adj;
  logic [BCD_W+BIN_W-1:0] shift_word;
  logic [5:0][6:0]        seg_result;

  assign sel_value = showHS ? highScore : score;

  // Segment patterns for the finished BCD value, blanking leading zeros.
  // NOTE: every variable written in an always_comb gets a default first;
  // otherwise a path that skips an assignment infers a latch.
  always_comb begin
    logic leading;
    seg_result = '{default: SEG_OFF};
    leading    = 1'b1;
    for (int i = 5; i >= 1; i--) begin
      if (bcd_q[i*4 +: 4] != 4'd0) begin
        leading = 1'b0;
      end
      seg_result[i] = leading ? SEG_OFF : seg_encode(bcd_q[i*4 +: 4]);
    end
    seg_result[0] = seg_encode(bcd_q[3:0]);
  end

  // Next-state and datapath logic for the converter FSM.
  always_comb begin
    state_d      = state_q;
    last_value_d = last_value_q;
    last_sel_d   = last_sel_q;
    bin_d        = bin_q;
    bcd_d        = bcd_q;
    cnt_d        = cnt_q;
    pend_ovf_d   = pend_ovf_q;
    seg_d        = seg_q;
    ovf_d        = ovf_q;
    bcd_adj      = dabble_adjust(bcd_q);
    shift_word   = {bcd_adj, bin_q} << 1;

    case (state_q)
      IDLE: begin
        // The selection is captured here so that later input changes cannot
        // leak into a conversion already under way.
        if ((sel_value != last_value_q) || (showHS != last_sel_q)) begin
          last_value_d = sel_value;
          last_sel_d   = showHS;
          state_d      = LOAD;
        end
      end
      LOAD: begin
        if (last_value_q > MAX_V32) begin
          bin_d      = MAX_V20;
          pend_ovf_d = 1'b1;
        end else begin
          bin_d      = last_value_q[BIN_W-1:0];
          pend_ovf_d = 1'b0;
        end
        bcd_d   = '0;
        cnt_d   = '0;
        state_d = SHIFT;
      end
      SHIFT: begin
        bcd_d = shift_word[BCD_W+BIN_W-1:BIN_W];
        bin_d = shift_word[BIN_W-1:0];
        cnt_d = cnt_q + 5'd1;
        if (cnt_q == LAST_SHIFT) begin
          state_d = DONE;
        end
      end
      DONE: begin
        // Digits and overflow are committed in the same cycle.
        seg_d   = seg_result;
        ovf_d   = pend_ovf_q;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // State register with synchronous active-low reset.
  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge values, independent of statement order.
  always_ff @(posedge Clock) begin
    if (!reset) begin
      state_q      <= IDLE;
      last_value_q <= '0;
      last_sel_q   <= 1'b0;
      bin_q        <= '0;
      bcd_q        <= '0;
      cnt_q        <= '0;
      pend_ovf_q   <= 1'b0;
      seg_q        <= {{5{SEG_OFF}}, SEG_ZERO};
      ovf_q        <= 1'b0;
      blank_q      <= 1'b0;
    end else begin
      state_q      <= state_d;
      last_value_q <= last_value_d;
      last_sel_q   <= last_sel_d;
      bin_q        <= bin_d;
      bcd_q        <= bcd_d;
      cnt_q        <= cnt_d;
      pend_ovf_q   <= pend_ovf_d;
      seg_q        <= seg_d;
      ovf_q        <= ovf_d;
      blank_q      <= blank;
    end
  end

  // Blanking only masks the outputs; the stored digits stay intact.
  assign HEX0     = blank_q ? SEG_OFF : seg_q[0];
  assign HEX1     = blank_q ? SEG_OFF : seg_q[1];
  assign HEX2     = blank_q ? SEG_OFF : seg_q[2];
  assign HEX3     = blank_q ? SEG_OFF : seg_q[3];
  assign HEX4     = blank_q ? SEG_OFF : seg_q[4];
  assign HEX5     = blank_q ? SEG_OFF : seg_q[5];
  assign busy     = (state_q != IDLE);
  assign overflow = ovf_q;

endmodule

// File: tb/tb_score_display.sv
// Testbench for score_display: directed stimulus pushes expected displays into a
// scoreboard queue; a monitor pops and compares whenever busy falls.
module tb_score_display;

  localparam logic [6:0] S_OFF = 7'b1111111;
  localparam logic [6:0] S0 = 7'b1000000;
  localparam logic [6:0] S1 = 7'b1111001;
  localparam logic [6:0] S2 = 7'b0100100;
  localparam logic [6:0] S3 = 7'b0110000;
  localparam logic [6:0] S4 = 7'b0011001;
  localparam logic [6:0] S5 = 7'b0010010;
  localparam logic [6:0] S6 = 7'b0000010;
  localparam logic [6:0] S7 = 7'b1111000;
  localparam logic [6:0] S8 = 7'b0000000;
  localparam logic [6:0] S9 = 7'b0010000;

  localparam logic [41:0] DISP_RESET = {S_OFF, S_OFF, S_OFF, S_OFF, S_OFF, S0};
  localparam logic [41:0] DISP_DARK  = {6{S_OFF}};
  localparam logic [41:0] DISP_999K  = {6{S9}};

  typedef struct {
    logic [41:0] hex;
    logic        ovf;
    int          blen;   // expected busy length; 0 = aborted conversion
  } exp_t;

  logic        Clock = 1'b0;
  logic        reset;
  logic [31:0] score;
  logic [31:0] highScore;
  logic        showHS;
  logic        blank;
  logic [6:0]  HEX0, HEX1, HEX2, HEX3, HEX4, HEX5;
  logic        busy;
  logic        overflow;
  logic [41:0] cur_hex;

  exp_t sb_q[$];
  int   errors = 0;
  int   checks = 0;
  int   popped = 0;

  score_display #(.MAX_VALUE(999999)) dut (
    .Clock    (Clock),
    .reset    (reset),
    .score    (score),
    .highScore(highScore),
    .showHS   (showHS),
    .blank    (blank),
    .HEX0     (HEX0),
    .HEX1     (HEX1),
    .HEX2     (HEX2),
    .HEX3     (HEX3),
    .HEX4     (HEX4),
    .HEX5     (HEX5),
    .busy     (busy),
    .overflow (overflow)
  );

  always #5 Clock = ~Clock;

  assign cur_hex = {HEX5, HEX4, HEX3, HEX2, HEX1, HEX0};

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge Clock);
    #1;
  endtask

  task automatic expect_conv(input logic [41:0] hex, input logic ovf, input int blen);
    exp_t e;
    e.hex  = hex;
    e.ovf  = ovf;
    e.blen = blen;
    sb_q.push_back(e);
  endtask

  task automatic wait_pops(input int n);
    int k;
    k = 0;
    while (popped < n && k < 100) begin
      tick();
      k++;
    end
    check("conv_done", 64'(popped), 64'(n));
  endtask

  // Monitor: a falling busy marks a finished (or aborted) conversion.
  logic prev_busy = 1'b0;
  int   blen_cnt  = 0;
  always @(negedge Clock) begin
    exp_t e;
    if (busy === 1'b1) begin
      blen_cnt++;
    end else if (prev_busy === 1'b1) begin
      if (sb_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_conv: got hex=%h with no expected entry", cur_hex);
      end else begin
        e = sb_q.pop_front();
        check("conv_hex", 64'(cur_hex), 64'(e.hex));
        check("conv_ovf", 64'(overflow), 64'(e.ovf));
        if (e.blen != 0) check("busy_len", 64'(blen_cnt), 64'(e.blen));
      end
      popped++;
      blen_cnt = 0;
    end
    prev_busy = busy;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    score     = 0;
    highScore = 0;
    showHS    = 0;
    blank     = 0;
    reset     = 0;
    repeat (3) tick();
    reset = 1;
    check("rst_hex", 64'(cur_hex), 64'(DISP_RESET));
    check("rst_busy", 64'(busy), 64'(0));
    check("rst_ovf", 64'(overflow), 64'(0));
    repeat (30) tick();
    check("idle_busy", 64'(busy), 64'(0));
    check("idle_hex", 64'(cur_hex), 64'(DISP_RESET));
    check("idle_no_conv", 64'(popped), 64'(0));

    // 123, with a look at the outputs mid-conversion.
    score = 123;
    expect_conv({S_OFF, S_OFF, S_OFF, S1, S2, S3}, 1'b0, 22);
    repeat (10) tick();
    check("busy_mid", 64'(busy), 64'(1));
    check("no_partial", 64'(cur_hex), 64'(DISP_RESET));
    wait_pops(1);

    // Saturation, then a small value clears overflow.
    score = 1234567;
    expect_conv(DISP_999K, 1'b1, 22);
    wait_pops(2);
    score = 42;
    expect_conv({S_OFF, S_OFF, S_OFF, S_OFF, S4, S2}, 1'b0, 22);
    wait_pops(3);

    // Source selection.
    score     = 7;
    highScore = 250;
    expect_conv({S_OFF, S_OFF, S_OFF, S_OFF, S_OFF, S7}, 1'b0, 22);
    wait_pops(4);
    showHS = 1;
    expect_conv({S_OFF, S_OFF, S_OFF, S2, S5, S0}, 1'b0, 22);
    wait_pops(5);
    showHS = 0;
    expect_conv({S_OFF, S_OFF, S_OFF, S_OFF, S_OFF, S7}, 1'b0, 22);
    wait_pops(6);

    // Change mid-conversion: first shows 5, then re-converts to 6.
    score = 5;
    expect_conv({S_OFF, S_OFF, S_OFF, S_OFF, S_OFF, S5}, 1'b0, 22);
    repeat (12) tick();
    score = 6;
    expect_conv({S_OFF, S_OFF, S_OFF, S_OFF, S_OFF, S6}, 1'b0, 22);
    wait_pops(8);

    // Exactly MAX_VALUE with blank asserted mid-conversion.
    score = 999999;
    expect_conv(DISP_DARK, 1'b0, 22);
    repeat (5) tick();
    blank = 1;
    tick();
    check("blank_on", 64'(cur_hex), 64'(DISP_DARK));
    wait_pops(9);
    check("blank_hold", 64'(cur_hex), 64'(DISP_DARK));
    blank = 0;
    tick();
    check("blank_off", 64'(cur_hex), 64'(DISP_999K));
    check("max_ovf", 64'(overflow), 64'(0));

    // One above MAX_VALUE saturates.
    score = 1000000;
    expect_conv(DISP_999K, 1'b1, 22);
    wait_pops(10);

    // Reset in the middle of SHIFT, then 88 after release.
    score = 77;
    expect_conv(DISP_RESET, 1'b0, 0);
    repeat (8) tick();
    check("busy_pre_rst", 64'(busy), 64'(1));
    reset = 0;
    score = 88;
    tick();
    check("midrst_hex", 64'(cur_hex), 64'(DISP_RESET));
    check("midrst_busy", 64'(busy), 64'(0));
    check("midrst_ovf", 64'(overflow), 64'(0));
    reset = 1;
    expect_conv({S_OFF, S_OFF, S_OFF, S_OFF, S8, S8}, 1'b0, 22);
    wait_pops(12);

    repeat (5) tick();
    check("sb_empty", 64'(sb_q.size()), 64'(0));
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
